// File: rtl/cpu_sequencer_if.sv
// ============================================================================
// Module  : cpu_sequencer_if
// Purpose : Control/status bundle between the CPU sequencer and the datapath.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface cpu_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic               run;
    logic               step;
    logic               execute_flag;
    logic [10:0]        alu_ctl;
    logic [3:0]         rd;
    logic               mem_ready;
    logic               instruction_en;
    logic               pc_load;
    logic               read_en;
    logic               ldr_str_en;
    logic               mem_req;
    logic               write_en;
    logic               lr_write;
    logic               pc_wb_load;
    logic               halted;
    logic               mem_err;
    logic [2:0]         state;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  run, step, execute_flag, alu_ctl, rd, mem_ready,
        output instruction_en, pc_load, read_en, ldr_str_en, mem_req,
               write_en, lr_write, pc_wb_load, halted, mem_err, state,
               instr_count
    );

    modport slave (
        output run, step, execute_flag, alu_ctl, rd, mem_ready,
        input  instruction_en, pc_load, read_en, ldr_str_en, mem_req,
               write_en, lr_write, pc_wb_load, halted, mem_err, state,
               instr_count
    );
endinterface

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module  : cpu_sequencer
// Purpose : Multi-cycle instruction sequencer with run/halt/step control.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cpu_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [10:0] c_ALU_CMP = 11'd8;
    localparam logic [10:0] c_ALU_BL  = 11'd32;
    localparam logic [10:0] c_ALU_LDR = 11'd41;
    localparam logic [10:0] c_ALU_STR = 11'd42;
    // Wait counter starts at 0 on MEM entry, so cycle N in MEM sees N-1.
    localparam logic [7:0]  c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next;
    state_t               w_exit_state;
    logic                 r_step_pending;
    logic [7:0]           r_wait;
    logic                 r_mem_err;
    logic [COUNT_W-1:0]   r_count;
    logic                 w_set_pending;
    logic                 w_clr_pending;
    logic                 w_exit_clr;
    logic                 w_retire;
    logic                 w_abort;
    logic                 w_instruction_en;
    logic                 w_pc_load;
    logic                 w_read_en;
    logic                 w_ldr_str_en;
    logic                 w_mem_req;
    logic                 w_write_en;
    logic                 w_lr_write;
    logic                 w_pc_wb_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_HALT;
            r_step_pending <= 1'b0;
            r_wait         <= 8'd0;
            r_mem_err      <= 1'b0;
            r_count        <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_pending)
                r_step_pending <= 1'b1;
            else if (w_clr_pending)
                r_step_pending <= 1'b0;
            r_wait <= (r_state == S_MEM) ? r_wait + 8'd1 : 8'd0;
            if (w_abort)
                r_mem_err <= 1'b1;
            if (w_retire)
                r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_set_pending    = 1'b0;
        w_clr_pending    = 1'b0;
        w_retire         = 1'b0;
        w_abort          = 1'b0;
        w_instruction_en = 1'b0;
        w_pc_load        = 1'b0;
        w_read_en        = 1'b0;
        w_ldr_str_en     = 1'b0;
        w_mem_req        = 1'b0;
        w_write_en       = 1'b0;
        w_lr_write       = 1'b0;
        w_pc_wb_load     = 1'b0;

        // Instruction boundary: continue only when free-running, not stepping.
        if (bus.run && !r_step_pending) begin
            w_exit_state = S_FETCH;
            w_exit_clr   = 1'b0;
        end else begin
            w_exit_state = S_HALT;
            w_exit_clr   = 1'b1;
        end

        case (r_state)
            S_HALT: begin
                if (bus.run) begin
                    w_next = S_FETCH;
                end else if (bus.step) begin
                    w_set_pending = 1'b1;
                    w_next        = S_FETCH;
                end
            end
            S_FETCH: begin
                w_instruction_en = 1'b1;
                w_pc_load        = 1'b1;
                w_next           = S_DECODE;
            end
            S_DECODE: begin
                w_read_en = bus.execute_flag;
                if (!bus.execute_flag) begin
                    w_retire      = 1'b1;
                    w_clr_pending = w_exit_clr;
                    w_next        = w_exit_state;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.alu_ctl == c_ALU_LDR || bus.alu_ctl == c_ALU_STR)
                    w_next = S_MEM;
                else
                    w_next = S_WB;
            end
            S_MEM: begin
                w_ldr_str_en = 1'b1;
                w_mem_req    = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_WB;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_abort       = 1'b1;
                    w_clr_pending = 1'b1;
                    w_next        = S_HALT;
                end
            end
            S_WB: begin
                w_retire      = 1'b1;
                w_clr_pending = w_exit_clr;
                w_next        = w_exit_state;
                if (bus.alu_ctl == c_ALU_CMP || bus.alu_ctl == c_ALU_STR) begin
                    w_write_en = 1'b0;
                end else if (bus.alu_ctl == c_ALU_BL) begin
                    w_write_en = 1'b1;
                    w_lr_write = 1'b1;
                end else if (bus.rd == 4'd15) begin
                    w_pc_wb_load = 1'b1;
                end else begin
                    w_write_en = 1'b1;
                end
            end
            default: w_next = S_HALT;
        endcase
    end

    assign bus.instruction_en = w_instruction_en;
    assign bus.pc_load        = w_pc_load;
    assign bus.read_en        = w_read_en;
    assign bus.ldr_str_en     = w_ldr_str_en;
    assign bus.mem_req        = w_mem_req;
    assign bus.write_en       = w_write_en;
    assign bus.lr_write       = w_lr_write;
    assign bus.pc_wb_load     = w_pc_wb_load;
    assign bus.halted         = (r_state == S_HALT);
    assign bus.mem_err        = r_mem_err;
    assign bus.state          = r_state;
    assign bus.instr_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// Module  : tb_cpu_sequencer
// Purpose : Directed, table-driven bench for cpu_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;
    localparam int COUNT_W = 16;

    localparam logic [7:0] SB_0  = 8'h00;
    localparam logic [7:0] SB_F  = 8'hC0;
    localparam logic [7:0] SB_D  = 8'h20;
    localparam logic [7:0] SB_M  = 8'h18;
    localparam logic [7:0] SB_W  = 8'h04;
    localparam logic [7:0] SB_BL = 8'h06;
    localparam logic [7:0] SB_PC = 8'h01;

    typedef struct {
        logic        rst;
        logic        run;
        logic        step;
        logic        ef;
        logic [10:0] alu;
        logic [3:0]  rd;
        logic        mr;
        logic [2:0]  st;
        logic [7:0]  sb;
        logic        merr;
        logic [15:0] cnt;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vq[$];

    cpu_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

    cpu_sequencer #(.MEM_TIMEOUT(15), .COUNT_W(COUNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] observe();
        return {bus.state, bus.instruction_en, bus.pc_load, bus.read_en,
                bus.ldr_str_en, bus.mem_req, bus.write_en, bus.lr_write,
                bus.pc_wb_load, bus.halted, bus.mem_err, bus.instr_count};
    endfunction

    task automatic add(input logic r, input logic ru, input logic s, input logic ef,
                       input int alu, input int rdv, input logic mr, input int st,
                       input logic [7:0] sb, input logic merr, input int cnt,
                       input string name);
        vec_t v;
        v.rst = r; v.run = ru; v.step = s; v.ef = ef;
        v.alu = 11'(alu); v.rd = 4'(rdv); v.mr = mr;
        v.st = 3'(st); v.sb = sb; v.merr = merr; v.cnt = 16'(cnt); v.name = name;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic ru, input logic s, input logic ef,
                         input int alu, input int rdv, input logic mr);
        rst = r; bus.run = ru; bus.step = s; bus.execute_flag = ef;
        bus.alu_ctl = 11'(alu); bus.rd = 4'(rdv); bus.mem_ready = mr;
    endtask

    task automatic check(input string name, input int st, input logic [7:0] sb,
                         input logic merr, input int cnt);
        logic [28:0] exp;
        logic [28:0] act;
        exp = {3'(st), sb, (st == 0), merr, 16'(cnt)};
        act = observe();
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got st=%0d sb=%h h=%b err=%b cnt=%0d, want st=%0d sb=%h h=%b err=%b cnt=%0d",
                     name, act[28:26], act[25:18], act[17], act[16], act[15:0],
                     exp[28:26], exp[25:18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);

        //  rst run stp ef  alu rd mr  st  strobes merr cnt
        add(1, 0, 0, 1,   4,  3, 0, 0, SB_0,  0, 0, "reset");
        add(0, 1, 0, 1,   4,  3, 0, 0, SB_0,  0, 0, "alu_halt");
        add(0, 1, 0, 1,   4,  3, 0, 1, SB_F,  0, 0, "alu_fetch");
        add(0, 1, 0, 1,   4,  3, 0, 2, SB_D,  0, 0, "alu_decode");
        add(0, 1, 0, 1,   4,  3, 0, 3, SB_0,  0, 0, "alu_exec");
        add(0, 1, 0, 1,   4,  3, 0, 5, SB_W,  0, 0, "alu_wb");
        add(0, 1, 0, 1,  41,  2, 0, 1, SB_F,  0, 1, "ldr_fetch");
        add(0, 1, 0, 1,  41,  2, 0, 2, SB_D,  0, 1, "ldr_decode");
        add(0, 1, 0, 1,  41,  2, 0, 3, SB_0,  0, 1, "ldr_exec");
        add(0, 1, 0, 1,  41,  2, 0, 4, SB_M,  0, 1, "ldr_mem1");
        add(0, 1, 0, 1,  41,  2, 0, 4, SB_M,  0, 1, "ldr_mem2");
        add(0, 1, 0, 1,  41,  2, 0, 4, SB_M,  0, 1, "ldr_mem3");
        add(0, 1, 0, 1,  41,  2, 1, 4, SB_M,  0, 1, "ldr_mem4");
        add(0, 1, 0, 1,  41,  2, 0, 5, SB_W,  0, 1, "ldr_wb");
        add(0, 1, 0, 0,   4,  3, 0, 1, SB_F,  0, 2, "skip_fetch");
        add(0, 1, 0, 0,   4,  3, 0, 2, SB_0,  0, 2, "skip_decode");
        add(0, 1, 0, 1,   4, 15, 0, 1, SB_F,  0, 3, "pc_fetch");
        add(0, 1, 0, 1,   4, 15, 0, 2, SB_D,  0, 3, "pc_decode");
        add(0, 1, 0, 1,   4, 15, 0, 3, SB_0,  0, 3, "pc_exec");
        add(0, 1, 0, 1,   4, 15, 0, 5, SB_PC, 0, 3, "pc_wb");
        add(0, 1, 0, 1,   4,  7, 0, 1, SB_F,  0, 4, "rst_fetch");
        add(0, 1, 0, 1,   4,  7, 0, 2, SB_D,  0, 4, "rst_decode");
        add(1, 1, 0, 1,   4,  7, 0, 3, SB_0,  0, 4, "rst_exec");
        add(0, 0, 0, 1,   4,  7, 0, 0, SB_0,  0, 0, "rst_halt");
        add(0, 1, 0, 1,   8,  5, 0, 0, SB_0,  0, 0, "cmp_halt");
        add(0, 0, 0, 1,   8,  5, 0, 1, SB_F,  0, 0, "cmp_fetch");
        add(0, 0, 0, 1,   8,  5, 0, 2, SB_D,  0, 0, "cmp_decode");
        add(0, 0, 0, 1,   8,  5, 0, 3, SB_0,  0, 0, "cmp_exec");
        add(0, 0, 0, 1,   8,  5, 0, 5, SB_0,  0, 0, "cmp_wb");
        add(0, 0, 0, 1,  32,  0, 0, 0, SB_0,  0, 1, "cmp_halted");
        add(0, 0, 1, 1,  32,  0, 0, 0, SB_0,  0, 1, "bl_step");
        add(0, 0, 0, 1,  32,  0, 0, 1, SB_F,  0, 1, "bl_fetch");
        add(0, 0, 0, 1,  32,  0, 0, 2, SB_D,  0, 1, "bl_decode");
        add(0, 0, 0, 1,  32,  0, 0, 3, SB_0,  0, 1, "bl_exec");
        add(0, 0, 0, 1,  32,  0, 0, 5, SB_BL, 0, 1, "bl_wb");
        add(0, 0, 0, 1,  32,  0, 0, 0, SB_0,  0, 2, "bl_halted");
        add(0, 0, 0, 1,  42,  0, 0, 0, SB_0,  0, 2, "halt_hold");
        add(0, 0, 1, 1,  42,  0, 1, 0, SB_0,  0, 2, "str_step");
        add(0, 0, 0, 1,  42,  0, 1, 1, SB_F,  0, 2, "str_fetch");
        add(0, 0, 0, 1,  42,  0, 1, 2, SB_D,  0, 2, "str_decode");
        add(0, 0, 0, 1,  42,  0, 1, 3, SB_0,  0, 2, "str_exec");
        add(0, 0, 0, 1,  42,  0, 1, 4, SB_M,  0, 2, "str_mem");
        add(0, 0, 0, 1,  42,  0, 1, 5, SB_0,  0, 2, "str_wb");
        add(0, 0, 0, 1,  42,  0, 1, 0, SB_0,  0, 3, "str_halted");
        add(0, 1, 1, 1,   4,  1, 0, 0, SB_0,  0, 3, "runstep_halt");
        add(0, 1, 0, 1,   4,  1, 0, 1, SB_F,  0, 3, "runstep_fetch");
        add(0, 1, 0, 1,   4,  1, 0, 2, SB_D,  0, 3, "runstep_decode");
        add(0, 1, 0, 1,   4,  1, 0, 3, SB_0,  0, 3, "runstep_exec");
        add(0, 1, 0, 1,   4,  1, 0, 5, SB_W,  0, 3, "runstep_wb");
        add(0, 0, 0, 1,   4,  1, 0, 1, SB_F,  0, 4, "runstep_next");
        add(0, 0, 0, 1,   4,  1, 0, 2, SB_D,  0, 4, "stop_decode");
        add(0, 0, 0, 1,   4,  1, 0, 3, SB_0,  0, 4, "stop_exec");
        add(0, 0, 0, 1,   4,  1, 0, 5, SB_W,  0, 4, "stop_wb");
        add(0, 0, 0, 1,   4,  1, 0, 0, SB_0,  0, 5, "stop_halted");

        repeat (2) @(negedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].run, vq[i].step, vq[i].ef,
                  int'(vq[i].alu), int'(vq[i].rd), vq[i].mr);
            #1;
            check(vq[i].name, int'(vq[i].st), vq[i].sb, vq[i].merr, int'(vq[i].cnt));
        end

        // STR that never sees mem_ready: aborts on the 15th MEM cycle
        @(negedge clk); drive(0, 0, 1, 1, 42, 0, 0); #1; check("to_step",   0, SB_0, 0, 5);
        @(negedge clk); drive(0, 0, 0, 1, 42, 0, 0); #1; check("to_fetch",  1, SB_F, 0, 5);
        @(negedge clk); #1; check("to_decode", 2, SB_D, 0, 5);
        @(negedge clk); #1; check("to_exec",   3, SB_0, 0, 5);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk); #1; check($sformatf("to_mem%0d", i), 4, SB_M, 0, 5);
        end
        @(negedge clk); #1; check("to_abort", 0, SB_0, 1, 5);

        // LDR whose ack arrives on the 15th MEM cycle: ready beats timeout
        @(negedge clk); drive(0, 1, 0, 1, 41, 2, 0); #1; check("rw_halt", 0, SB_0, 1, 5);
        @(negedge clk); #1; check("rw_fetch",  1, SB_F, 1, 5);
        @(negedge clk); #1; check("rw_decode", 2, SB_D, 1, 5);
        @(negedge clk); #1; check("rw_exec",   3, SB_0, 1, 5);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            bus.mem_ready = (i == 15);
            #1; check($sformatf("rw_mem%0d", i), 4, SB_M, 1, 5);
        end
        @(negedge clk); drive(0, 0, 0, 1, 41, 2, 0); #1; check("rw_wb", 5, SB_W, 1, 5);
        @(negedge clk); #1; check("rw_halted", 0, SB_0, 1, 6);
        @(negedge clk); drive(1, 0, 0, 1, 41, 2, 0); #1; check("err_rst",  0, SB_0, 1, 6);
        @(negedge clk); drive(0, 0, 0, 1, 41, 2, 0); #1; check("err_clr",  0, SB_0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the single-issue CPU datapath. It replaces the free-running 2-bit cycle counter with an explicit state machine that drives the stage strobes for each instruction: fetch, register read, load/store, register write. It also handles condition-failed skips, stretches the memory stage until the memory acknowledges, and provides run, halt and single-step control for the serial debugger. It sits beside the decoder and owns the PC update and write-enable strobes.

## Interface
- MEM_TIMEOUT, 15: maximum cycles spent in MEM waiting for `mem_ready` before abort (1..255).
- COUNT_W, 16: width of the retired-instruction counter.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  1 = free-run; 0 = stop at the next instruction boundary.
- step  in  1  single-cycle pulse; executes one instruction while halted.
- execute_flag  in  1  condition-code pass from decoder; valid in DECODE.
- alu_ctl  in  11  decoded ALU control code; valid from DECODE through WB.
- rd  in  4  destination register field.
- mem_ready  in  1  memory access complete; sampled in MEM.
- instruction_en  out  1  instruction memory fetch enable.
- pc_load  out  1  load PC from next-PC logic.
- read_en  out  1  register file read enable.
- ldr_str_en  out  1  data memory access enable.
- mem_req  out  1  memory request; held until acknowledged.
- write_en  out  1  register file write enable.
- lr_write  out  1  select R14 and link value as write target (BL).
- pc_wb_load  out  1  load PC from writeback data (rd == 15).
- halted  out  1  1 while in HALT.
- mem_err  out  1  sticky memory-timeout flag.
- state  out  3  current state code, for the debug port.
- instr_count  out  COUNT_W  retired-instruction count; wraps modulo 2^COUNT_W.

## Operation
- State codes: HALT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Codes 6 and 7 go to HALT.
- All strobes are Moore decodes of the registered state, plus the stated qualifiers. Outside their states all strobes are 0.
- HALT
  - If `run`, go to FETCH.
  - Else if `step`, latch `step_pending`=1 and go to FETCH.
  - Else stay.
- FETCH: `instruction_en`=1, `pc_load`=1. Go to DECODE.
- DECODE: `read_en`=`execute_flag`.
  - If `execute_flag`=0, the instruction retires as skipped: `instr_count`+1, then go to RETIRE.
  - Else go to EXEC.
- EXEC: no strobes. If `alu_ctl` is 41 (LDR) or 42 (STR), go to MEM; else go to WB.
- MEM: `ldr_str_en`=1, `mem_req`=1, and the wait counter increments.
  - `mem_ready`=1: go to WB.
  - Wait counter reaches MEM_TIMEOUT with `mem_ready`=0: set `mem_err`=1, do not retire, go to HALT, clear `step_pending`.
  - `mem_ready` and timeout in the same cycle: ready wins.
- WB: retire (`instr_count`+1).
  - `alu_ctl`==8 (compare) or 42 (STR): no register write.
  - `alu_ctl`==32 (BL): `write_en`=1, `lr_write`=1.
  - Else if `rd`==15: `pc_wb_load`=1, `write_en`=0.
  - Else: `write_en`=1.
- RETIRE (not a state, the exit rule from DECODE-skip and WB):
  - If `run`=1 and `step_pending`=0, go to FETCH.
  - Else go to HALT and clear `step_pending`.
- `run` falling mid-instruction: the instruction completes, then HALT.
- `step` while `run`=1 or outside HALT is ignored.
- `mem_err` clears only on `rst`. HALT exits normally after an error.

## Timing
- Reset values: state=HALT, `halted`=1, all strobes 0, `mem_err`=0, `instr_count`=0, wait counter 0, `step_pending`=0.
- `rst` mid-instruction: HALT on the next edge. Strobes are 0 from that edge. No partial write completes.
- Latency in cycles, from FETCH entry to the next FETCH entry:
  - ALU op or branch: 4.
  - Condition-failed: 2.
  - Load/store: 5 + N, where N is the count of MEM cycles with `mem_ready`=0.
- HALT to FETCH: 1 cycle after `run` or `step` is sampled high.
- The wait counter clears on every MEM entry. The timeout abort occurs on the MEM_TIMEOUT-th cycle in MEM.
- `instr_count` increments on the edge leaving DECODE-skip or WB.

## Test plan
- Reset, then `run`=1, `execute_flag`=1, `alu_ctl`=4, `rd`=3 → state sequence 1,2,3,5,1. `write_en` high for exactly one cycle in WB. `instr_count`=1 after 4 cycles.
- LDR (`alu_ctl`=41) with `mem_ready` low for 3 MEM cycles → MEM lasts 4 cycles and `mem_req` is held the whole time. WB follows with `write_en`=1. Instruction takes 8 cycles.
- `execute_flag`=0 in DECODE → `read_en`=0, no EXEC/MEM/WB, `instr_count`+1, back in FETCH 2 cycles after FETCH entry.
- Halted, pulse `step` for one cycle with a BL (`alu_ctl`=32) → `lr_write`=1 and `write_en`=1 in WB, then HALT with `halted`=1 and `instr_count`=1.
- STR with `mem_ready` held 0 and MEM_TIMEOUT=15 → abort after 15 MEM cycles, `mem_err`=1, HALT, `instr_count` unchanged. A later `rst` clears `mem_err`.
- `rd`=15 ALU op → `pc_wb_load`=1 and `write_en`=0 in WB. Assert `rst` during EXEC → HALT next edge with all strobes 0.
